alu16_datapath: RTL and testbench
=================================

Name: alu16_datapath

Overview:
- Registered 16-bit ALU datapath: operand/opcode input registers, combinational function units and a result accumulator register with arithmetic status flags.
- Sits between the opcode source and the downstream result consumer.
- Exposes the final result plus carry, overflow and error status.

Parameters:
- WIDTH, 16, data width of operands and result (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; ignored for NOT, SHR, SHL and CLEAR
- opcode  input  4  operation select
- result  output  WIDTH  accumulator register contents
- carry  output  1  registered carry-out of the last ADD/SUB
- overflow  output  1  registered signed overflow of the last ADD/SUB
- error  output  1  registered; overflow qualified by the captured op being ADD or SUB

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 NOT(A), 0011 XOR
  - 0100 NAND, 0101 NOR, 0110 XNOR
  - 1000 ADD, 1001 SUB (A-B)
  - 1010 SHR, 1011 SHL
  - 1111 CLEAR; every unlisted code (0111, 1100-1110) behaves as CLEAR.
- Stage 1: every rising edge captures a, b and opcode into a_q, b_q and op_q.
- Stage 2: every rising edge loads result, carry, overflow and error from the function of a_q, b_q and op_q.
- Latency: inputs presented before edge N appear on the outputs after edge N+1. Throughput is one op per cycle.
- Reset (rst_n low, asynchronous): a_q, b_q and result go to 0; op_q goes to CLEAR; carry, overflow and error go to 0. Reset mid-pipeline discards all in-flight ops. The first valid output follows the second edge after reset release.
- Logic ops are bitwise over WIDTH bits.
- Shifts are logical, by 1, on A, with zero fill:
  - SHR: result = {0, A[W-1:1]}
  - SHL: result = {A[W-2:0], 0}
- ADD: {carry, sum} = A + B.
- SUB: A + ~B + 1; carry is the raw carry-out (1 = no borrow).
- overflow = (A_msb == B'_msb) && (sum_msb != A_msb), where B' = B for ADD and ~B for SUB.
- Result on overflow is the wrapped WIDTH-bit sum.
- Flags: carry and overflow update only for ADD/SUB; every other op forces both to 0. error = overflow for ADD/SUB, else 0.
- CLEAR: result = 0 and all flags = 0.
- X on b during ops that ignore B must not affect outputs, and b_q still captures it. No handshake; all inputs are sampled every cycle.

Decomposition:
- Package alu16_pkg holds:
  - 4-bit opcode localparams: OP_AND, OP_OR, OP_NOT, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_CLEAR
  - an opcode-to-mnemonic function for benches.
- One natural sub-module, alu16_addsub: combinational add/subtract with a sub control, outputs sum, carry and overflow.
- Logic, shift and result selection stay inline in alu16_datapath.

Test Plan:
- Reset: assert rst_n=0 mid-stream with ADD in flight -> result=0x0000 and carry=overflow=error=0 immediately (asynchronously). After release, 2 edges pass before the first valid result.
- Logic sweep: a=0x250A, b=0x3C5F, one op per cycle, each result exactly 2 edges after its op is applied:
  - AND -> 0x240A
  - OR -> 0x3D5F
  - XOR -> 0x1955
  - NAND -> 0xDBF5
  - NOR -> 0xC2A0
  - XNOR -> 0xE6AA
  - NOT with a=0x0F0F, b=X -> 0xF0F0
- Shifts: a=0xCE67, b=X. SHR -> 0x6733; SHL -> 0x9CCE; flags 0.
- ADD:
  - 0x001E+0x0007 -> 0x0025, carry=0, overflow=0, error=0
  - 0xBC40+0x9C40 -> 0x5880, carry=1, overflow=1, error=1
- SUB:
  - 0x0007-0x001E -> 0xFFE9, carry=0, overflow=0
  - 0x001E-0x0007 -> 0x0017, carry=1, overflow=0
  - 0x8000-0x0001 -> 0x7FFF, overflow=1, error=1
- CLEAR and illegal: alternate ADD with CLEAR (1111), then opcode 1101 -> result=0 and all flags cleared on the CLEAR/illegal cycles. Back-to-back ops pipeline correctly with no bubbles.

Source files
------------

// File: rtl/alu16_pkg.sv
// Shared opcode encodings and helper types for the registered 16-bit ALU datapath.
package alu16_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_NOT   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NAND  = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_XNOR  = 4'b0110;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_SHR   = 4'b1010;
    localparam logic [3:0] OP_SHL   = 4'b1011;
    localparam logic [3:0] OP_CLEAR = 4'b1111;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic error;
    } alu_flags_t;

    // Five-character ASCII mnemonic, for log messages in benches.
    function automatic logic [39:0] op_name(input logic [3:0] op);
        logic [39:0] name;
        case (op)
            OP_AND:   name = "AND  ";
            OP_OR:    name = "OR   ";
            OP_NOT:   name = "NOT  ";
            OP_XOR:   name = "XOR  ";
            OP_NAND:  name = "NAND ";
            OP_NOR:   name = "NOR  ";
            OP_XNOR:  name = "XNOR ";
            OP_ADD:   name = "ADD  ";
            OP_SUB:   name = "SUB  ";
            OP_SHR:   name = "SHR  ";
            OP_SHL:   name = "SHL  ";
            OP_CLEAR: name = "CLEAR";
            default:  name = "ILLOP";
        endcase
        return name;
    endfunction

endpackage

// File: rtl/alu16_addsub.sv
// Combinational adder/subtractor: sub selects A + ~B + 1, carry is the raw carry-out.
module alu16_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;

    always_comb begin
        b_eff    = sub ? ~b : b;
        full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum      = full_sum[WIDTH-1:0];
        carry    = full_sum[WIDTH];
        // Signed overflow: like-signed operands producing a sum of the other sign.
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu16_datapath.sv
// Two-stage ALU: operand/opcode capture registers feeding function units and a
// result register with carry, overflow and error status.
module alu16_datapath
    import alu16_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             error
);

    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] result_d, result_q;
    alu_flags_t       flags_d, flags_q;

    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_CLEAR;
        end else begin
            a_q  <= a;
            b_q  <= b;
            op_q <= opcode;
        end
    end

    alu16_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a        (a_q),
        .b        (b_q),
        .sub      (op_q == OP_SUB),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_overflow)
    );

    // Flags default to zero so only ADD/SUB can raise them; B-independent ops never
    // route b_q to the result.
    always_comb begin
        result_d = '0;
        flags_d  = '0;
        case (op_q)
            OP_AND:  result_d = a_q & b_q;
            OP_OR:   result_d = a_q | b_q;
            OP_NOT:  result_d = ~a_q;
            OP_XOR:  result_d = a_q ^ b_q;
            OP_NAND: result_d = ~(a_q & b_q);
            OP_NOR:  result_d = ~(a_q | b_q);
            OP_XNOR: result_d = ~(a_q ^ b_q);
            OP_SHR:  result_d = {1'b0, a_q[WIDTH-1:1]};
            OP_SHL:  result_d = {a_q[WIDTH-2:0], 1'b0};
            OP_ADD, OP_SUB: begin
                result_d         = as_sum;
                flags_d.carry    = as_carry;
                flags_d.overflow = as_overflow;
                flags_d.error    = as_overflow;
            end
            default: begin
                result_d = '0;
                flags_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result   = result_q;
    assign carry    = flags_q.carry;
    assign overflow = flags_q.overflow;
    assign error    = flags_q.error;

endmodule

// File: tb/tb_alu16_datapath.sv
// Self-checking bench: directed and random ops against an arithmetic reference model.
module tb_alu16_datapath;
    import alu16_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  opcode;
    logic [15:0] result;
    logic        carry;
    logic        overflow;
    logic        error;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        o;
        logic        e;
        logic [3:0]  op;
    } exp_t;

    exp_t exp_q[$];

    alu16_datapath #(
        .WIDTH (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .opcode   (opcode),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer arithmetic, signed range check for overflow.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                   input logic [3:0] op);
        exp_t x;
        int ua, ub, sa, sb, u, s;
        ua = {16'h0000, av};
        ub = {16'h0000, bv};
        sa = {{16{av[15]}}, av};
        sb = {{16{bv[15]}}, bv};
        x.r = 16'h0000;
        x.c = 1'b0;
        x.o = 1'b0;
        x.op = op;
        case (op)
            OP_AND:  x.r = av & bv;
            OP_OR:   x.r = av | bv;
            OP_NOT:  x.r = ~av;
            OP_XOR:  x.r = av ^ bv;
            OP_NAND: x.r = ~(av & bv);
            OP_NOR:  x.r = ~(av | bv);
            OP_XNOR: x.r = ~(av ^ bv);
            OP_SHR:  x.r = av >> 1;
            OP_SHL:  x.r = av << 1;
            OP_ADD: begin
                u = ua + ub;
                s = sa + sb;
                x.r = u[15:0];
                x.c = (u > 65535);
                x.o = (s > 32767) || (s < -32768);
            end
            OP_SUB: begin
                u = ua - ub;
                s = sa - sb;
                x.r = u[15:0];
                x.c = (ua >= ub);
                x.o = (s > 32767) || (s < -32768);
            end
            default: x.r = 16'h0000;
        endcase
        x.e = x.o;
        return x;
    endfunction

    task automatic check_out(input exp_t x);
        checks++;
        assert (result === x.r) else begin
            errors++;
            $error("FAIL %s result: got %h expected %h", op_name(x.op), result, x.r);
        end
        checks++;
        assert (carry === x.c) else begin
            errors++;
            $error("FAIL %s carry: got %b expected %b", op_name(x.op), carry, x.c);
        end
        checks++;
        assert (overflow === x.o) else begin
            errors++;
            $error("FAIL %s overflow: got %b expected %b", op_name(x.op), overflow, x.o);
        end
        checks++;
        assert (error === x.e) else begin
            errors++;
            $error("FAIL %s error: got %b expected %b", op_name(x.op), error, x.e);
        end
    endtask

    // Apply one op, clock it, and check whatever op is due on the outputs now.
    task automatic step(input logic [15:0] av, input logic [15:0] bv, input logic [3:0] op,
                        input logic b_is_x);
        a = av;
        b = b_is_x ? 16'hxxxx : bv;
        opcode = op;
        exp_q.push_back(model(av, bv, op));
        @(posedge clk);
        #1;
        if (exp_q.size() > 1) check_out(exp_q.pop_front());
    endtask

    task automatic reset_queue();
        exp_t z;
        exp_q.delete();
        z = model(16'h0000, 16'h0000, OP_CLEAR);
        exp_q.push_back(z);
    endtask

    initial begin
        exp_t zero;
        zero = model(16'h0000, 16'h0000, OP_CLEAR);
        rst_n = 1'b0;
        a = 16'h0000;
        b = 16'h0000;
        opcode = OP_CLEAR;
        #3;
        check_out(zero);
        #20;
        rst_n = 1'b1;
        reset_queue();
        #1;

        // Logic sweep
        step(16'h250A, 16'h3C5F, OP_AND,  1'b0);
        step(16'h250A, 16'h3C5F, OP_OR,   1'b0);
        step(16'h250A, 16'h3C5F, OP_XOR,  1'b0);
        step(16'h250A, 16'h3C5F, OP_NAND, 1'b0);
        step(16'h250A, 16'h3C5F, OP_NOR,  1'b0);
        step(16'h250A, 16'h3C5F, OP_XNOR, 1'b0);
        step(16'h0F0F, 16'h0000, OP_NOT,  1'b1);
        // Shifts with B undriven
        step(16'hCE67, 16'h0000, OP_SHR,  1'b1);
        step(16'hCE67, 16'h0000, OP_SHL,  1'b1);
        // Add / subtract corners
        step(16'h001E, 16'h0007, OP_ADD,  1'b0);
        step(16'hBC40, 16'h9C40, OP_ADD,  1'b0);
        step(16'h0007, 16'h001E, OP_SUB,  1'b0);
        step(16'h001E, 16'h0007, OP_SUB,  1'b0);
        step(16'h8000, 16'h0001, OP_SUB,  1'b0);
        // CLEAR / illegal interleaved with overflowing ADDs
        step(16'hBC40, 16'h9C40, OP_ADD,  1'b0);
        step(16'h1234, 16'h5678, OP_CLEAR, 1'b0);
        step(16'h7FFF, 16'h0001, OP_ADD,  1'b0);
        step(16'h7FFF, 16'h0001, OP_CLEAR, 1'b0);
        step(16'hFFFF, 16'hFFFF, OP_ADD,  1'b0);
        step(16'hFFFF, 16'hFFFF, 4'b1101, 1'b0);
        step(16'hAAAA, 16'h5555, 4'b0111, 1'b0);

        // Asynchronous reset with an overflowing ADD in flight
        step(16'hBC40, 16'h9C40, OP_ADD, 1'b0);
        step(16'hBC40, 16'h9C40, OP_ADD, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out(zero);
        #3;
        rst_n = 1'b1;
        reset_queue();

        // Random ops, all 16 codes
        for (int i = 0; i < 300; i++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            step(16'($urandom), 16'($urandom), rop, 1'b0);
        end

        // Drain the pipeline
        step(16'h0000, 16'h0000, OP_CLEAR, 1'b0);
        step(16'h0000, 16'h0000, OP_CLEAR, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
